csr_file: RTL and testbench

- Machine-mode CSR register file for the pipelined RV32I core. Sits in the execute stage, directly downstream of the immediate generator.
- Consumes the CSR address (immediate bits [11:0]), funct3, rs1 data / zimm and the PC of the instruction in the stage.
- Performs CSRRW/S/C(I) read-modify-write, runs the 64-bit cycle counter, samples timer/external interrupts, and produces trap-entry and mret PC redirects for the fetch stage.

---
 rtl/csr_pkg.sv | 47 ++++
 rtl/csr_cycle_counter.sv | 29 ++
 rtl/csr_file.sv | 169 ++++++++++++++++
 tb/tb_csr_file.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encoding,
// trap causes and the bit positions of the implemented status/enable/pending fields.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef enum logic [2:0] {
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_e;

  localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIE_MTIE_BIT     = 7;
  localparam int unsigned MIE_MEIE_BIT     = 11;
  localparam int unsigned MIP_MTIP_BIT     = 7;
  localparam int unsigned MIP_MEIP_BIT     = 11;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                            input logic [31:0] src);
    case (op)
      CSR_OP_RW, CSR_OP_RWI: csr_apply = src;
      CSR_OP_RS, CSR_OP_RSI: csr_apply = old_val | src;
      CSR_OP_RC, CSR_OP_RCI: csr_apply = old_val & ~src;
      default:               csr_apply = old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_cycle_counter.sv
// 64-bit free-running cycle counter; either half can be overwritten, and the
// increment is held off in any cycle that carries a write.
module csr_cycle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic        inc_inhibit,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (we_lo) cnt_d[31:0]  = wdata;
    if (we_hi) cnt_d[63:32] = wdata;
    if (!inc_inhibit) cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file for the execute stage: CSR read-modify-write, cycle
// counter, interrupt sampling and trap-entry / mret redirects to fetch.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic [11:0] csr_addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic        is_mret,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic        mtie_q, mtie_d, meie_q, meie_d;
  logic        mtip_q, mtip_d, meip_q, meip_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;

  logic [63:0] cycle_cnt;
  logic [31:0] old_val, src, wval;
  logic        is_rw, do_write, take, mei_pend, mti_pend;
  logic        cyc_we_lo, cyc_we_hi;

  assign src   = funct3[2] ? {27'b0, zimm} : rs1_data;
  assign is_rw = (funct3[1:0] == 2'b01);
  assign wval  = csr_apply(csr_op_e'(funct3), old_val, src);

  assign mei_pend = meie_q & meip_q;
  assign mti_pend = mtie_q & mtip_q;
  assign take     = instr_valid & mie_q & (mei_pend | mti_pend);

  // Set/clear with a zero source is a pure read and must not disturb the CSR.
  assign do_write = csr_en & ~is_mret & ~take & (funct3[1:0] != 2'b00)
                  & (is_rw | (src != 32'd0));

  assign cyc_we_lo = do_write & (csr_addr == CSR_MCYCLE);
  assign cyc_we_hi = do_write & (csr_addr == CSR_MCYCLEH);

  always_comb begin
    old_val = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        old_val[MSTATUS_MIE_BIT]  = mie_q;
        old_val[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MIE: begin
        old_val[MIE_MTIE_BIT] = mtie_q;
        old_val[MIE_MEIE_BIT] = meie_q;
      end
      CSR_MIP: begin
        old_val[MIP_MTIP_BIT] = mtip_q;
        old_val[MIP_MEIP_BIT] = meip_q;
      end
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      CSR_MCYCLE:   old_val = cycle_cnt[31:0];
      CSR_MCYCLEH:  old_val = cycle_cnt[63:32];
      CSR_MHARTID:  old_val = HART_ID;
      default:      old_val = '0;
    endcase
  end

  assign csr_rdata = csr_en ? old_val : 32'd0;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtie_d     = mtie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtip_d     = timer_irq;
    meip_d     = ext_irq;
    if (take) begin
      mepc_d   = pc & ALIGN_MASK;
      mcause_d = mei_pend ? MCAUSE_MEI : MCAUSE_MTI;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (is_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (do_write) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_d  = wval[MSTATUS_MIE_BIT];
          mpie_d = wval[MSTATUS_MPIE_BIT];
        end
        CSR_MIE: begin
          mtie_d = wval[MIE_MTIE_BIT];
          meie_d = wval[MIE_MEIE_BIT];
        end
        CSR_MTVEC:    mtvec_d    = wval & ALIGN_MASK;
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = wval & ALIGN_MASK;
        CSR_MCAUSE:   mcause_d   = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtip_q     <= 1'b0;
      meip_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & ALIGN_MASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtie_q     <= mtie_d;
      meie_q     <= meie_d;
      mtip_q     <= mtip_d;
      meip_q     <= meip_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  csr_cycle_counter u_cycle (
    .clk         (clk),
    .rst         (rst),
    .we_lo       (cyc_we_lo),
    .we_hi       (cyc_we_hi),
    .inc_inhibit (cyc_we_lo | cyc_we_hi),
    .wdata       (wval),
    .count       (cycle_cnt)
  );

  // Trap entry outranks mret; nothing redirects while reset is held.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    if (!rst) begin
      if (take) begin
        redirect    = 1'b1;
        redirect_pc = mtvec_q;
      end else if (is_mret) begin
        redirect    = 1'b1;
        redirect_pc = mepc_q;
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: expectations are queued as each step is driven
// and popped against the DUT outputs shortly after the inputs settle.
module tb_csr_file;

  localparam logic [31:0] MTVEC_R = 32'h0000_0203;
  localparam logic [31:0] HART    = 32'd5;

  logic        clk = 1'b0;
  logic        rst, csr_en, is_mret, instr_valid, timer_irq, ext_irq;
  logic [11:0] csr_addr;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, pc, csr_rdata, redirect_pc;
  logic [4:0]  zimm;
  logic        redirect;

  always #5 clk = ~clk;

  csr_file #(.MTVEC_RESET(MTVEC_R), .HART_ID(HART)) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_en      (csr_en),
    .csr_addr    (csr_addr),
    .funct3      (funct3),
    .rs1_data    (rs1_data),
    .zimm        (zimm),
    .is_mret     (is_mret),
    .instr_valid (instr_valid),
    .pc          (pc),
    .timer_irq   (timer_irq),
    .ext_irq     (ext_irq),
    .csr_rdata   (csr_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam int S_RDATA = 0, S_REDIR = 1, S_RPC = 2;

  task automatic drive(input logic r, input logic en, input logic [2:0] f3,
                       input logic [11:0] a, input logic [31:0] d, input logic [4:0] z,
                       input logic m, input logic iv, input logic [31:0] p);
    rst = r; csr_en = en; funct3 = f3; csr_addr = a; rs1_data = d; zimm = z;
    is_mret = m; instr_valid = iv; pc = p;
  endtask

  task automatic push(input string tag, input int sig, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.sig = sig; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_adv();
    #1;
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] obs;
      e = sb.pop_front();
      case (e.sig)
        S_RDATA: obs = csr_rdata;
        S_REDIR: obs = {31'b0, redirect};
        default: obs = redirect_pc;
      endcase
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                    input logic [4:0] z, input logic [31:0] exp_rd, input string tag);
    drive(1'b0, 1'b1, f3, a, d, z, 1'b0, 1'b0, 32'd0);
    push(tag, S_RDATA, exp_rd);
    push({tag, "_redir"}, S_REDIR, 32'd0);
    check_adv();
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string tag);
    op(3'b010, a, 32'd0, 5'd0, e, tag);
  endtask

  task automatic idle_iv(input logic iv, input logic [31:0] p, input logic exp_redir,
                         input logic [31:0] exp_pc, input string tag);
    drive(1'b0, 1'b0, 3'b000, 12'h000, 32'd0, 5'd0, 1'b0, iv, p);
    push({tag, "_redir"}, S_REDIR, {31'b0, exp_redir});
    if (exp_redir) push({tag, "_pc"}, S_RPC, exp_pc);
    check_adv();
  endtask

  initial begin
    timer_irq = 1'b0;
    ext_irq   = 1'b0;
    drive(1'b1, 1'b0, 3'b000, 12'h000, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    push("rst_redir", S_REDIR, 32'd0);
    push("rst_rdata", S_RDATA, 32'd0);
    check_adv();

    rd(12'h300, 32'd0, "rst_mstatus");
    rd(12'h305, 32'h0000_0200, "rst_mtvec");
    rd(12'hF14, HART, "mhartid");
    rd(12'h304, 32'd0, "rst_mie");

    // mscratch read-modify-write forms
    op(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd0, 32'd0, "rw_mscratch");
    rd(12'h340, 32'hDEAD_BEEF, "rs0_mscratch");
    op(3'b011, 12'h340, 32'd0, 5'd0, 32'hDEAD_BEEF, "rc0_mscratch");
    op(3'b010, 12'h340, 32'h0000_0010, 5'd0, 32'hDEAD_BEEF, "rs_mscratch");
    op(3'b011, 12'h340, 32'h0000_00FF, 5'd0, 32'hDEAD_BEFF, "rc_mscratch");
    op(3'b101, 12'h340, 32'hFFFF_FFFF, 5'd5, 32'hDEAD_BE00, "rwi_mscratch");
    rd(12'h340, 32'd5, "rwi_result");

    op(3'b001, 12'h344, 32'hFFFF_FFFF, 5'd0, 32'd0, "mip_wr");
    rd(12'h344, 32'd0, "mip_ro");
    op(3'b001, 12'hF14, 32'h1234_0000, 5'd0, HART, "hartid_wr");
    rd(12'hF14, HART, "hartid_ro");
    op(3'b001, 12'h305, 32'h0000_1003, 5'd0, 32'h0000_0200, "mtvec_wr");
    rd(12'h305, 32'h0000_1000, "mtvec_align");
    op(3'b001, 12'h341, 32'h0000_0203, 5'd0, 32'd0, "mepc_wr");
    rd(12'h341, 32'h0000_0200, "mepc_align");

    // timer interrupt: one cycle from pin to pending
    op(3'b110, 12'h300, 32'd0, 5'd8, 32'd0, "mstatus_setmie");
    op(3'b010, 12'h304, 32'h0000_0080, 5'd0, 32'd0, "mie_mtie");
    timer_irq = 1'b1;
    idle_iv(1'b1, 32'h100, 1'b0, 32'd0, "mti_latency");
    idle_iv(1'b1, 32'h100, 1'b1, 32'h1000, "mti_take");
    rd(12'h341, 32'h0000_0100, "mti_mepc");
    rd(12'h342, 32'h8000_0007, "mti_mcause");
    rd(12'h300, 32'h0000_0080, "mti_mstatus");
    rd(12'h344, 32'h0000_0080, "mip_mtip");

    // both pending: external wins
    ext_irq = 1'b1;
    op(3'b010, 12'h304, 32'h0000_0800, 5'd0, 32'h0000_0080, "mie_meie");
    op(3'b110, 12'h300, 32'd0, 5'd8, 32'h0000_0080, "mstatus_mie2");
    idle_iv(1'b1, 32'h200, 1'b1, 32'h1000, "mei_take");
    rd(12'h342, 32'h8000_000B, "mei_mcause");
    rd(12'h300, 32'h0000_0080, "mei_mstatus");
    rd(12'h341, 32'h0000_0200, "mei_mepc");
    rd(12'h344, 32'h0000_0880, "mip_both");
    timer_irq = 1'b0;
    ext_irq   = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 12'h000, 32'd0, 5'd0, 1'b1, 1'b1, 32'h204);
    push("mret_redir", S_REDIR, 32'd1);
    push("mret_pc", S_RPC, 32'h0000_0200);
    check_adv();
    rd(12'h300, 32'h0000_0088, "mret_mstatus");
    rd(12'h344, 32'd0, "mip_clear");

    // interrupt taken in the same cycle as a CSR write
    timer_irq = 1'b1;
    idle_iv(1'b0, 32'd0, 1'b0, 32'd0, "pre_irq");
    drive(1'b0, 1'b1, 3'b001, 12'h340, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 32'h300);
    push("irq_wr_redir", S_REDIR, 32'd1);
    push("irq_wr_pc", S_RPC, 32'h0000_1000);
    push("irq_wr_rdata", S_RDATA, 32'd5);
    check_adv();
    timer_irq = 1'b0;
    rd(12'h340, 32'd5, "irq_wr_mscratch");
    rd(12'h341, 32'h0000_0300, "irq_wr_mepc");
    rd(12'h300, 32'h0000_0080, "irq_wr_mstatus");

    // mret and CSR write together: mret wins
    drive(1'b0, 1'b1, 3'b001, 12'h340, 32'h0000_AAAA, 5'd0, 1'b1, 1'b1, 32'h304);
    push("mret_csr_redir", S_REDIR, 32'd1);
    push("mret_csr_pc", S_RPC, 32'h0000_0300);
    check_adv();
    rd(12'h340, 32'd5, "mret_csr_mscratch");
    rd(12'h300, 32'h0000_0088, "mret_csr_mstatus");

    // cycle counter wrap; write cycles do not increment
    drive(1'b0, 1'b1, 3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 32'd0);
    push("mcycle_wr_redir", S_REDIR, 32'd0);
    check_adv();
    op(3'b001, 12'hB80, 32'hFFFF_FFFF, 5'd0, 32'd0, "mcycleh_wr");
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_noinc");
    rd(12'hB80, 32'd0, "mcycleh_wrap");
    rd(12'hB00, 32'd1, "mcycle_wrap");

    // reset while counting and while a trap is being taken
    timer_irq = 1'b1;
    idle_iv(1'b0, 32'd0, 1'b0, 32'd0, "pre_rst");
    drive(1'b1, 1'b0, 3'b000, 12'h000, 32'd0, 5'd0, 1'b0, 1'b1, 32'h400);
    timer_irq = 1'b0;
    check_adv();
    drive(1'b0, 1'b1, 3'b010, 12'hB00, 32'd0, 5'd0, 1'b0, 1'b1, 32'h404);
    push("post_rst_redir", S_REDIR, 32'd0);
    push("post_rst_mcycle", S_RDATA, 32'd0);
    check_adv();
    rd(12'hB80, 32'd0, "post_rst_mcycleh");
    rd(12'h300, 32'd0, "post_rst_mstatus");
    rd(12'h340, 32'd0, "post_rst_mscratch");
    rd(12'h341, 32'd0, "post_rst_mepc");
    rd(12'h342, 32'd0, "post_rst_mcause");
    rd(12'h304, 32'd0, "post_rst_mie");
    rd(12'h305, 32'h0000_0200, "post_rst_mtvec");
    op(3'b001, 12'h7C0, 32'hFFFF_FFFF, 5'd0, 32'd0, "unimpl_wr");
    rd(12'h7C0, 32'd0, "unimpl_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
